// File: rtl/rsa_exp_sequencer.sv
// Exponent sequencer: walks a latched exponent MSB-first and issues the
// Montgomery square/multiply sequence, driving only operand selects and handshakes.
module rsa_exp_sequencer #(
    parameter int T_WIDTH   = 32,
    parameter int LEN_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [T_WIDTH-1:0]   exp_t,
    input  logic [LEN_WIDTH-1:0] exp_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 mont_start,
    input  logic                 mont_done,
    output logic [2:0]           mont_a_sel,
    output logic [2:0]           mont_b_sel,
    output logic                 mont_dst_sel,
    output logic [7:0]           op_count
);
    localparam int IDX_W = (T_WIDTH > 1) ? $clog2(T_WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [1:0] OP_TOMONT = 2'd0;
    localparam logic [1:0] OP_SQR    = 2'd1;
    localparam logic [1:0] OP_MUL    = 2'd2;
    localparam logic [1:0] OP_FROM   = 2'd3;

    localparam logic [2:0] SEL_ACC = 3'd0;
    localparam logic [2:0] SEL_XT  = 3'd1;
    localparam logic [2:0] SEL_M   = 3'd2;
    localparam logic [2:0] SEL_R2N = 3'd3;
    localparam logic [2:0] SEL_ONE = 3'd4;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   bit_q, bit_d;
    logic [T_WIDTH-1:0] exp_q, exp_d;
    logic               len_bad_q, len_bad_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mont_start_q, mont_start_d;
    logic [2:0]         a_sel_q, a_sel_d;
    logic [2:0]         b_sel_q, b_sel_d;
    logic               dst_q, dst_d;
    logic [7:0]         op_count_q, op_count_d;
    logic               enter_issue;
    logic               len_bad;

    assign len_bad = (exp_len == '0) || (int'(exp_len) > T_WIDTH);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        bit_d        = bit_q;
        exp_d        = exp_q;
        len_bad_d    = len_bad_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        mont_start_d = 1'b0;
        a_sel_d      = a_sel_q;
        b_sel_d      = b_sel_q;
        dst_d        = dst_q;
        op_count_d   = op_count_q;
        enter_issue  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d      = exp_t;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    op_count_d = '0;
                    busy_d     = 1'b1;
                    len_bad_d  = len_bad;
                    if (len_bad) begin
                        state_d = S_FIN;
                    end else begin
                        op_d        = OP_TOMONT;
                        bit_d       = IDX_W'(exp_len - LEN_WIDTH'(1));
                        state_d     = S_ISSUE;
                        enter_issue = 1'b1;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mont_done) begin
                    if (op_q == OP_FROM) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = S_ISSUE;
                        enter_issue = 1'b1;
                        // bit_q already points at the MSB after TOMONT
                        if (op_q == OP_TOMONT) begin
                            op_d = OP_SQR;
                        end else if (op_q == OP_SQR && exp_q[bit_q]) begin
                            op_d = OP_MUL;
                        end else if (bit_q == '0) begin
                            op_d = OP_FROM;
                        end else begin
                            op_d  = OP_SQR;
                            bit_d = bit_q - IDX_W'(1);
                        end
                    end
                end
            end
            default: begin
                done_d  = 1'b1;
                err_d   = len_bad_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (enter_issue) begin
            mont_start_d = 1'b1;
            if (op_count_d != 8'hFF) op_count_d = op_count_d + 8'd1;
            case (op_d)
                OP_TOMONT: begin a_sel_d = SEL_M;   b_sel_d = SEL_R2N; dst_d = 1'b1; end
                OP_SQR:    begin a_sel_d = SEL_ACC; b_sel_d = SEL_ACC; dst_d = 1'b0; end
                OP_MUL:    begin a_sel_d = SEL_ACC; b_sel_d = SEL_XT;  dst_d = 1'b0; end
                default:   begin a_sel_d = SEL_ACC; b_sel_d = SEL_ONE; dst_d = 1'b0; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            op_q         <= OP_TOMONT;
            bit_q        <= '0;
            exp_q        <= '0;
            len_bad_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mont_start_q <= 1'b0;
            a_sel_q      <= '0;
            b_sel_q      <= '0;
            dst_q        <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            bit_q        <= bit_d;
            exp_q        <= exp_d;
            len_bad_q    <= len_bad_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            mont_start_q <= mont_start_d;
            a_sel_q      <= a_sel_d;
            b_sel_q      <= b_sel_d;
            dst_q        <= dst_d;
            op_count_q   <= op_count_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign mont_start   = mont_start_q;
    assign mont_a_sel   = a_sel_q;
    assign mont_b_sel   = b_sel_q;
    assign mont_dst_sel = dst_q;
    assign op_count     = op_count_q;
endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Bench for rsa_exp_sequencer: table-driven jobs, random jobs against a
// square-and-multiply reference, stall/noise, error and mid-run reset sequences.
module tb_rsa_exp_sequencer;
    logic        clk = 1'b0;
    logic        resetn, start, mont_done;
    logic [31:0] exp_t;
    logic [5:0]  exp_len;
    logic        busy, done, err, mont_start, mont_dst_sel;
    logic [2:0]  mont_a_sel, mont_b_sel;
    logic [7:0]  op_count;

    int total = 0;
    int passed = 0;
    logic [6:0] got_q[$];
    logic [6:0] ref_q[$];

    typedef struct {
        logic [31:0] e;
        logic [5:0]  l;
        int          lat;
        int          nops;
    } vec_t;
    vec_t tbl[8];

    rsa_exp_sequencer #(.T_WIDTH(32), .LEN_WIDTH(6)) dut (
        .clk(clk), .resetn(resetn), .start(start), .exp_t(exp_t), .exp_len(exp_len),
        .busy(busy), .done(done), .err(err), .mont_start(mont_start), .mont_done(mont_done),
        .mont_a_sel(mont_a_sel), .mont_b_sel(mont_b_sel), .mont_dst_sel(mont_dst_sel),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain MSB-first square-and-multiply op list, encoded {a,b,dst}.
    function automatic void build_ref(input logic [31:0] e, input logic [5:0] l);
        ref_q.delete();
        ref_q.push_back({3'd2, 3'd3, 1'b1});
        for (int i = int'(l) - 1; i >= 0; i--) begin
            ref_q.push_back({3'd0, 3'd0, 1'b0});
            if (e[i]) ref_q.push_back({3'd0, 3'd1, 1'b0});
        end
        ref_q.push_back({3'd0, 3'd4, 1'b0});
    endfunction

    task automatic run_job(input logic [31:0] e, input logic [5:0] l, input int lat,
                           input bit noise, input int abort_at, input int nops);
        int cnt, tmo, terr, mism;
        bit bad;
        logic [6:0] held;
        got_q.delete();
        cnt = -1; tmo = 0; terr = 0; held = '0;
        bad = (l == 0) || (l > 6'd32);
        @(negedge clk);
        exp_t = e; exp_len = l; start = 1'b1; mont_done = 1'b0;
        @(negedge clk);
        start = 1'b0; exp_t = $urandom; exp_len = 6'($urandom);
        if (bad) begin
            check("err_k1", 32'({done, err, busy, mont_start}), 32'b0010);
            @(negedge clk);
            check("err_k2", 32'({done, err, busy, mont_start}), 32'b1100);
            check("err_opcnt", 32'(op_count), 32'd0);
            return;
        end
        check("accept", 32'({busy, done, err, mont_start}), 32'b1001);
        while (tmo < 20000) begin
            if (done) break;
            start = 1'b0; mont_done = 1'b0;
            if (mont_start) begin
                held = {mont_a_sel, mont_b_sel, mont_dst_sel};
                got_q.push_back(held);
                cnt = lat;
                if (abort_at == got_q.size()) begin
                    resetn = 1'b0;
                    #1;
                    check("abort_zero", 32'({busy, done, err, mont_start, mont_a_sel,
                          mont_b_sel, mont_dst_sel, op_count}), 32'd0);
                    @(negedge clk);
                    resetn = 1'b1;
                    return;
                end
                if (noise) mont_done = 1'b1;
            end else if (cnt > 0) begin
                if ({mont_a_sel, mont_b_sel, mont_dst_sel} != held || !busy) terr++;
                cnt--;
                if (cnt == 0) mont_done = 1'b1;
                else if (noise) begin start = 1'b1; exp_t = $urandom; exp_len = 6'd5; end
            end else begin
                terr++;
            end
            @(negedge clk);
            tmo++;
        end
        mont_done = 1'b0; start = 1'b0;
        check("timeout", 32'(tmo < 20000), 32'd1);
        check("timing", 32'(terr), 32'd0);
        build_ref(e, l);
        mism = 0;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] !== ref_q[i]) mism++;
        check("nops", 32'(got_q.size()), 32'(ref_q.size()));
        check("seq", 32'(mism), 32'd0);
        check("op_count", 32'(op_count), 32'(ref_q.size()));
        if (nops >= 0) check("tbl_nops", 32'(got_q.size()), 32'(nops));
        check("final", 32'({done, err, busy, mont_start}), 32'b1000);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; mont_done = 1'b0; exp_t = '0; exp_len = '0;
        tbl[0] = '{32'h0000_9985, 6'd16, 5, 25};
        tbl[1] = '{32'h0000_0000, 6'd1,  2, 3};
        tbl[2] = '{32'hFFFF_FFFF, 6'd32, 1, 66};
        tbl[3] = '{32'h0000_1234, 6'd0,  1, 0};
        tbl[4] = '{32'h0000_1234, 6'd33, 1, 0};
        tbl[5] = '{32'h0000_0005, 6'd3,  3, 7};
        tbl[6] = '{32'h8000_0000, 6'd32, 2, 35};
        tbl[7] = '{32'h0000_00F0, 6'd4,  1, 6};

        repeat (2) @(negedge clk);
        check("reset", 32'({busy, done, err, mont_start, mont_a_sel, mont_b_sel,
              mont_dst_sel, op_count}), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_job(tbl[i].e, tbl[i].l, tbl[i].lat, 1'b0, 0, tbl[i].nops);
            if (i == 0) begin
                @(negedge clk);
                check("done_level", 32'({done, busy}), 32'b10);
            end
        end

        // long multiplier stall with start and mont_done noise
        run_job(32'h0000_9985, 6'd16, 100, 1'b1, 0, 25);

        // reset after op 7, then a full clean rerun
        run_job(32'h0000_9985, 6'd16, 3, 1'b0, 7, -1);
        run_job(32'h0000_9985, 6'd16, 2, 1'b0, 0, 25);

        for (int i = 0; i < 15; i++)
            run_job($urandom, 6'($urandom_range(1, 32)), $urandom_range(1, 4),
                    1'($urandom_range(0, 1)), 0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
